// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the board's display and input paths.
//   CLK_FREQ_HZ              : system clock frequency
//   DEBOUNCE_CYCLES_DEFAULT  : default debounce time (1 ms at CLK_FREQ_HZ)
//   btn_state_e              : 2-bit debounce state encoding
package button_conditioner_pkg;

  localparam int CLK_FREQ_HZ             = 12_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_FREQ_HZ / 1000;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

endpackage

// File: rtl/debounce_channel.sv
// Single-button conditioner: polarity correction, 2-flop synchronizer,
// debounce FSM with stability counter, registered press/release pulses.
//   CLK   : system clock
//   RST   : synchronous active-high reset
//   raw   : asynchronous, bouncing pad input
//   level : debounced state, 1 = pressed
//   press : one-cycle pulse on the cycle level first reads 1
//   rel   : one-cycle pulse on the cycle level first reads 0
//
// state       | meaning
// ------------+-----------------------------------------------------
// RELEASED    | level 0, waiting for a pressed sample
// ARM_PRESS   | counting consecutive pressed samples
// PRESSED     | level 1, waiting for a released sample
// ARM_RELEASE | counting consecutive released samples
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic INV             = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer flops hold the polarity-corrected value so that reset
  // leaves them at "released" regardless of pin polarity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      state  <= RELEASED;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_a <= raw ^ INV;
      sync_b <= sync_a;
      press  <= 1'b0;
      rel    <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync_b) begin
            cnt   <= '0;
            state <= ARM_PRESS;
          end
        end
        ARM_PRESS: begin
          if (!sync_b) begin
            cnt   <= '0;
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= PRESSED;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync_b) begin
            cnt   <= '0;
            state <= ARM_RELEASE;
          end
        end
        ARM_RELEASE: begin
          if (sync_b) begin
            cnt   <= '0;
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RELEASED;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= RELEASED;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-button pins into clean CLK-synchronous signals.
//   CLK         : system clock
//   RST         : synchronous active-high reset
//   btn_raw     : raw pad inputs (asynchronous, bouncing)
//   btn_level   : debounced state per button, 1 = pressed
//   btn_press   : one-cycle pulse when btn_level rises
//   btn_release : one-cycle pulse when btn_level falls
// INV_MASK bit i = 1 marks channel i as active-low at the pin.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [N_BTN-1:0] INV_MASK        = 4'b1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INV            (INV_MASK[i])
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule
